// File: rtl/rregs_pkg.sv
// -----------------------------------------------------------------------------
// rregs_pkg
// Shared constants and the elaboration-time parameter check for the generic
// pipeline register (rregs) and its single-stage building block (rregs_stage).
// -----------------------------------------------------------------------------
package rregs_pkg;

    // Default geometry: a single 1-bit flop.
    localparam int RREGS_DEF_WIDTH = 32'sd1;
    localparam int RREGS_DEF_DEPTH = 32'sd1;

    // Returns 1 when the requested geometry is legal (at least one bit and
    // at least one stage).
    function automatic bit rregs_params_ok(input int width, input int depth);
        return (width >= 32'sd1) && (depth >= 32'sd1);
    endfunction

endpackage : rregs_pkg

// File: rtl/rregs_stage.sv
// -----------------------------------------------------------------------------
// rregs_stage
// One WIDTH-bit register with synchronous active-high reset to RESET_VAL and a
// clock enable. Reset has priority over enable; with enable low the stage holds.
//
// Ports:
//   clk_i    in   1      clock, rising edge
//   reset_i  in   1      synchronous reset, active high
//   en_i     in   1      clock enable
//   d_i      in   WIDTH  data in
//   q_o      out  WIDTH  registered data out
//
// Macro RREGS_INIT_EN: when defined, the stage is preloaded with RESET_VAL at
// time zero (simulation only) so its output is defined before the first edge.
// -----------------------------------------------------------------------------
module rregs_stage
    import rregs_pkg::*;
#(
    parameter int               WIDTH     = RREGS_DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next-state selection: load new data when enabled, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (en_i) begin
            q_d = d_i;
        end else begin
            q_d = q_q;
        end
    end

    // State register; synchronous reset overrides the enable path.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

`ifdef RREGS_INIT_EN
    // Simulation-only preload so the output is defined before any clock edge.
    initial begin
        q_q = RESET_VAL;
    end
`else
`endif

    assign q_o = q_q;

endmodule : rregs_stage

// File: rtl/rregs.sv
// -----------------------------------------------------------------------------
// rregs
// Generic positive-edge pipeline register: DEPTH chained WIDTH-bit stages that
// share one clock, one synchronous active-high reset and one clock enable.
// Data is only delayed, never transformed. Latency is DEPTH enabled edges;
// stall cycles (en low) hold every stage and lose nothing.
//
// Ports:
//   q      out  WIDTH                    last stage (DEPTH-1)
//   d      in   WIDTH                    data into stage 0
//   eph1   in   1                        clock, rising edge
//   reset  in   1                        synchronous reset, active high
//   en     in   1                        clock enable
//   taps   out  [DEPTH-1:0][WIDTH-1:0]   every stage; taps[DEPTH-1] == q
//
// Macro RREGS_INIT_EN: when defined, every stage starts at RESET_VAL at time
// zero in simulation; when undefined, stages are unknown until first reset.
// -----------------------------------------------------------------------------
module rregs
    import rregs_pkg::*;
#(
    parameter int               WIDTH     = RREGS_DEF_WIDTH,
    parameter int               DEPTH     = RREGS_DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    output logic [WIDTH-1:0]             q,
    input  logic [WIDTH-1:0]             d,
    input  logic                         eph1,
    input  logic                         reset,
    input  logic                         en,
    output logic [DEPTH-1:0][WIDTH-1:0]  taps
);

    // Reject illegal geometry at elaboration time.
    if (!rregs_params_ok(WIDTH, DEPTH)) begin : g_bad_params
        $error("rregs: WIDTH and DEPTH must both be >= 1");
    end

    logic [WIDTH-1:0] stage_q [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] stage_in;

        // Stage 0 takes the block input; later stages take their predecessor.
        if (i == 0) begin : g_head
            assign stage_in = d;
        end else begin : g_link
            assign stage_in = stage_q[i-1];
        end

        rregs_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk_i   (eph1),
            .reset_i (reset),
            .en_i    (en),
            .d_i     (stage_in),
            .q_o     (stage_q[i])
        );
    end

    // Expose every stage on the packed tap bus (pure wiring from flops).
    always_comb begin
        taps = '0;
        for (int i = 0; i < DEPTH; i++) begin
            taps[i] = stage_q[i];
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule : rregs

// File: tb/tb_rregs.sv
// -----------------------------------------------------------------------------
// tb_rregs: directed, self-checking bench for rregs across several
// parameterisations (default, 11-bit round constant, 128x15 key chain,
// 8x4 stall chain, 8x3 mid-stream reset, 8x1 with nonzero reset value).
// -----------------------------------------------------------------------------
module tb_rregs;

    logic eph1;
    logic rst;

    int n_tests;
    int n_fail;

    initial eph1 = 1'b0;
    always #5 eph1 = ~eph1;

    // ---------------- default instance (WIDTH=1, DEPTH=1) ----------------
    logic       def_d, def_en, def_q;
    logic [0:0][0:0] def_taps;
    rregs u_def (.q(def_q), .d(def_d), .eph1(eph1), .reset(rst), .en(def_en), .taps(def_taps));

    // ---------------- round constant (WIDTH=11, RESET_VAL=1) -------------
    logic [10:0]       rc_d, rc_q;
    logic              rc_en;
    logic [0:0][10:0]  rc_taps;
    rregs #(.WIDTH(11), .RESET_VAL(11'h001)) u_rc (
        .q(rc_q), .d(rc_d), .eph1(eph1), .reset(rst), .en(rc_en), .taps(rc_taps));

    // ---------------- key chain (WIDTH=128, DEPTH=15) --------------------
    logic [127:0]        rk_d, rk_q;
    logic                rk_en;
    logic [14:0][127:0]  rk_taps;
    rregs #(.WIDTH(128), .DEPTH(15)) u_rk (
        .q(rk_q), .d(rk_d), .eph1(eph1), .reset(rst), .en(rk_en), .taps(rk_taps));

    // ---------------- stall chain (WIDTH=8, DEPTH=4) ---------------------
    logic [7:0]       d4_d, d4_q;
    logic             d4_en;
    logic [3:0][7:0]  d4_taps;
    rregs #(.WIDTH(8), .DEPTH(4)) u_d4 (
        .q(d4_q), .d(d4_d), .eph1(eph1), .reset(rst), .en(d4_en), .taps(d4_taps));

    // ---------------- mid-stream reset (WIDTH=8, DEPTH=3) ----------------
    logic [7:0]       d3_d, d3_q;
    logic             d3_en;
    logic [2:0][7:0]  d3_taps;
    rregs #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) u_d3 (
        .q(d3_q), .d(d3_d), .eph1(eph1), .reset(rst), .en(d3_en), .taps(d3_taps));

    // ---------------- nonzero reset value (WIDTH=8, RESET_VAL=5) ---------
    logic [7:0]       i5_d, i5_q;
    logic             i5_en;
    logic [0:0][7:0]  i5_taps;
    rregs #(.WIDTH(8), .RESET_VAL(8'h05)) u_i5 (
        .q(i5_q), .d(i5_d), .eph1(eph1), .reset(rst), .en(i5_en), .taps(i5_taps));

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] d;
        logic [7:0] exp_q;
        logic [7:0] exp_t0;
    } vec_t;

    vec_t vecs [12];

    localparam logic [127:0] KEY = 128'hAB7F34AFDD7382220E089AFB3D909866;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wait for the next rising edge and settle 1ns after it.
    task automatic tick();
        @(posedge eph1);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        def_d = 1'b0; def_en = 1'b0;
        rc_d = 11'h000; rc_en = 1'b0;
        rk_d = 128'h0; rk_en = 1'b0;
        d4_d = 8'h00; d4_en = 1'b0;
        d3_d = 8'h00; d3_en = 1'b0;
        i5_d = 8'h00; i5_en = 1'b0;

        // stall-chain vector table: {rst, en, d, expected q, expected taps[0]}
        vecs[0]  = '{1'b1, 1'b0, 8'hAB, 8'h00, 8'h00};
        vecs[1]  = '{1'b1, 1'b1, 8'h00, 8'h00, 8'h00};
        vecs[2]  = '{1'b0, 1'b1, 8'h01, 8'h00, 8'h01};
        vecs[3]  = '{1'b0, 1'b1, 8'h02, 8'h00, 8'h02};
        vecs[4]  = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h02};
        vecs[5]  = '{1'b0, 1'b1, 8'h03, 8'h00, 8'h03};
        vecs[6]  = '{1'b0, 1'b1, 8'h04, 8'h01, 8'h04};
        vecs[7]  = '{1'b0, 1'b1, 8'h00, 8'h02, 8'h00};
        vecs[8]  = '{1'b0, 1'b1, 8'h00, 8'h03, 8'h00};
        vecs[9]  = '{1'b0, 1'b0, 8'h77, 8'h03, 8'h00};
        vecs[10] = '{1'b0, 1'b1, 8'h00, 8'h04, 8'h00};
        vecs[11] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00};

        #1;
`ifdef RREGS_INIT_EN
        check("init_q_time0", {120'h0, i5_q}, 128'h05);
`else
`endif

        // ---- stall chain, table driven ----
        for (int i = 0; i < 12; i++) begin
            rst   = vecs[i].rst;
            d4_en = vecs[i].en;
            d4_d  = vecs[i].d;
            tick();
            check($sformatf("d4_q[%0d]", i),  {120'h0, d4_q},       {120'h0, vecs[i].exp_q});
            check($sformatf("d4_t0[%0d]", i), {120'h0, d4_taps[0]}, {120'h0, vecs[i].exp_t0});
        end

        // ---- default params ----
        rst = 1'b1; def_en = 1'b1; def_d = 1'b1;
        tick();
        check("def_q_reset", {127'h0, def_q}, 128'h0);
        rst = 1'b0;
        tick();
        check("def_q_d1", {127'h0, def_q}, 128'h1);
        check("def_tap_eq_q", {127'h0, def_taps[0]}, 128'h1);
        def_d = 1'b0;
        tick();
        check("def_q_d0", {127'h0, def_q}, 128'h0);
        def_en = 1'b0; def_d = 1'b1;
        tick();
        check("def_q_hold", {127'h0, def_q}, 128'h0);

        // ---- round constant ----
        rst = 1'b1; rc_en = 1'b1; rc_d = 11'h7FF;
        tick();
        check("rc_reset", {117'h0, rc_q}, 128'h001);
        rst = 1'b0; rc_d = 11'h0D8;
        tick();
        check("rc_load", {117'h0, rc_q}, 128'h0D8);

        // ---- nonzero reset value ----
        rst = 1'b1; i5_en = 1'b1; i5_d = 8'h09;
        tick();
        check("i5_reset", {120'h0, i5_q}, 128'h05);
        rst = 1'b0;
        tick();
        check("i5_load", {120'h0, i5_q}, 128'h09);

        // ---- 128x15 key chain ----
        rst = 1'b1; rk_en = 1'b1; rk_d = 128'h0;
        tick();
        check("rk_reset_q", rk_q, 128'h0);
        rst = 1'b0; rk_d = KEY;
        for (int k = 1; k <= 16; k++) begin
            tick();
            rk_d = 128'h0;
            if (k <= 15) begin
                check($sformatf("rk_tap[%0d]", k - 1), rk_taps[k-1], KEY);
            end else begin
                check("rk_taps14_drain", rk_taps[14], 128'h0);
            end
            check($sformatf("rk_q_edge%0d", k), rk_q, (k == 15) ? KEY : 128'h0);
        end

        // ---- 8x3 mid-stream reset ----
        rst = 1'b1; d3_en = 1'b1; d3_d = 8'h00;
        tick();
        rst = 1'b0; d3_d = 8'hAA;
        tick(); tick(); tick();
        check("d3_filled", {120'h0, d3_q}, 128'hAA);
        rst = 1'b1; d3_d = 8'h55;
        tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("d3_rst_tap[%0d]", i), {120'h0, d3_taps[i]}, 128'h0);
        end
        rst = 1'b0; d3_d = 8'h55;
        tick();
        check("d3_after_rst_t0", {120'h0, d3_taps[0]}, 128'h55);
        check("d3_after_rst_q1", {120'h0, d3_q}, 128'h00);
        d3_d = 8'h00;
        tick();
        check("d3_after_rst_q2", {120'h0, d3_q}, 128'h00);
        tick();
        check("d3_after_rst_q3", {120'h0, d3_q}, 128'h55);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rregs
